ex_runmask_gen: RTL and testbench

EX_RUNMASK_GEN -- requirements
Module: ex_runmask_gen

---
 rtl/ex_runmask_gen_pkg.sv | 30 +++
 rtl/ex_runmask_byte.sv | 27 ++
 rtl/ex_runmask_gen.sv | 118 +++++++++++
 tb/tb_ex_runmask_gen.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_runmask_gen_pkg.sv
// Shared widths, FSM encoding and request record for the run-mask generator.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package ex_runmask_gen_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 6;
  localparam int BYTE_W = 8;
  // Per-byte run length spans 0..8, so it needs one bit more than a byte index.
  localparam int RUN_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUILD = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Operands latched at accept; n is already clamped to 0..32.
  typedef struct packed {
    logic              bit_val;
    logic [CNT_W-1:0]  n;
    logic [DATA_W-1:0] fill;
  } req_t;

  // Requested counts above the word width saturate to a full-word run.
  function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] c);
    return (c > CNT_W'(DATA_W)) ? CNT_W'(DATA_W) : c;
  endfunction

endpackage

// File: rtl/ex_runmask_byte.sv
// Builds one result byte: local leading run, optional terminator, fill for the rest.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
module ex_runmask_byte
  import ex_runmask_gen_pkg::*;
(
  input  logic              bit_val,
  input  logic [RUN_W-1:0]  run,
  input  logic              term,
  input  logic [BYTE_W-1:0] fill_byte,
  output logic [BYTE_W-1:0] byte_out
);

  // Bit j sits at local position 7-j counted from the byte MSB; the first
  // 'run' positions carry bit_val, the next one is the terminator if present.
  always_comb begin
    byte_out = fill_byte;
    for (int j = 0; j < BYTE_W; j++) begin
      if (RUN_W'(BYTE_W - 1 - j) < run) begin
        byte_out[j] = bit_val;
      end else if ((RUN_W'(BYTE_W - 1 - j) == run) && term) begin
        byte_out[j] = ~bit_val;
      end
    end
  end

endmodule

// File: rtl/ex_runmask_gen.sv
// Generates a 32-bit word with a leading run of n copies of bit_val, a terminator, then fill.
// Latency: out_valid rises 5 cycles after the accepting edge (4 byte writes + DONE entry).
// Backpressure: result held stable in DONE until out_ready; in_ready low outside IDLE.
module ex_runmask_gen
  import ex_runmask_gen_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              bit_val,
  input  logic [CNT_W-1:0]  count,
  input  logic [DATA_W-1:0] fill,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result
);

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        idx;
  // Set once byte 0 has been written, so DONE entry is an edge of its own.
  logic              settle;
  req_t              req;
  logic              accept;

  logic [CNT_W-1:0]  base;
  logic [CNT_W-1:0]  diff;
  logic [RUN_W-1:0]  run;
  logic              term;
  logic [BYTE_W-1:0] fill_byte;
  logic [BYTE_W-1:0] byte_out;

  assign accept = (state == IDLE) && in_valid && !flush;

  // Map the clamped word-level run onto the byte currently being built.
  // Byte idx holds word positions base..base+7 with base = (3-idx)*8.
  always_comb begin
    base      = {1'b0, ~idx, 3'b000};
    diff      = req.n - base;
    fill_byte = req.fill[{idx, 3'b000} +: BYTE_W];
    if (req.n < base) begin
      run  = '0;
      term = 1'b0;
    end else if (diff >= CNT_W'(BYTE_W)) begin
      run  = RUN_W'(BYTE_W);
      term = 1'b0;
    end else begin
      run  = diff[RUN_W-1:0];
      term = 1'b1;
    end
  end

  ex_runmask_byte u_byte (
    .bit_val   (req.bit_val),
    .run       (run),
    .term      (term),
    .fill_byte (fill_byte),
    .byte_out  (byte_out)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; flush overrides every other transition.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (in_valid)  state_nxt = BUILD;
        BUILD:   if (settle)    state_nxt = DONE;
        DONE:    if (out_ready) state_nxt = IDLE;
        default:                state_nxt = IDLE;
      endcase
    end
  end

  // Outputs decode the state register only, so no input reaches them combinationally.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Operand capture, byte index walk and result assembly; flush keeps result intact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= 2'd0;
      settle <= 1'b0;
      req    <= '0;
      result <= '0;
    end else if (flush) begin
      settle <= 1'b0;
    end else if (accept) begin
      idx         <= 2'd3;
      settle      <= 1'b0;
      req.bit_val <= bit_val;
      req.n       <= clamp_count(count);
      req.fill    <= fill;
    end else if ((state == BUILD) && !settle) begin
      result[{idx, 3'b000} +: BYTE_W] <= byte_out;
      if (idx == 2'd0) begin
        settle <= 1'b1;
      end else begin
        idx <= idx - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_ex_runmask_gen.sv
// Scoreboarded bench for ex_runmask_gen: directed corner cases plus random traffic.
// Latency: checks out_valid rises 5 cycles after each accept.
// Backpressure: exercises held and randomly toggled out_ready, flush and reset aborts.
module tb_ex_runmask_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic        bit_val;
  logic [5:0]  count;
  logic [31:0] fill;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;

  typedef struct {
    logic [31:0] word;
    int          n;
    logic        bv;
  } exp_t;

  exp_t        exp_q[$];
  int          lat_q[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  bit          bp_rand = 1'b0;
  logic [31:0] last_word;

  ex_runmask_gen dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bit_val   (bit_val),
    .count     (count),
    .fill      (fill),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: leading run of n bits, one opposite bit, then the fill bits.
  function automatic logic [31:0] ref_word(input logic bv, input int cnt, input logic [31:0] f);
    int          n;
    int          p;
    logic [31:0] w;
    n = (cnt > 32) ? 32 : cnt;
    for (int i = 0; i < 32; i++) begin
      p = 31 - i;
      if (p < n)       w[i] = bv;
      else if (p == n) w[i] = ~bv;
      else             w[i] = f[i];
    end
    return w;
  endfunction

  function automatic int lead_run(input logic [31:0] w, input logic bv);
    int k;
    k = 0;
    while ((k < 32) && (w[31-k] == bv)) k++;
    return k;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    if (bp_rand) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic bv, input logic [5:0] cnt, input logic [31:0] f);
    int   w;
    exp_t e;
    w = 0;
    while (!in_ready && (w < 200)) begin
      tick();
      w++;
    end
    if (!in_ready) begin
      check32("send_wait_ready", 32'(in_ready), 32'd1);
      return;
    end
    in_valid = 1'b1;
    bit_val  = bv;
    count    = cnt;
    fill     = f;
    e.word   = ref_word(bv, int'(cnt), f);
    e.n      = (cnt > 6'd32) ? 32 : int'(cnt);
    e.bv     = bv;
    exp_q.push_back(e);
    lat_q.push_back(cyc + 1);
    tick();
    in_valid = 1'b0;
    bit_val  = 1'($urandom);
    count    = 6'($urandom);
    fill     = $urandom;
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while ((exp_q.size() != 0) && (w < 2000)) begin
      tick();
      w++;
    end
    check32("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_out_valid();
    int w;
    w = 0;
    while (!out_valid && (w < 50)) begin
      tick();
      w++;
    end
    check32("wait_out_valid", 32'(out_valid), 32'd1);
  endtask

  // Monitor: latency on each rising out_valid, data on each handshake,
  // stability under backpressure, in_ready low while a result is held.
  logic        prev_vld = 1'b0;
  logic        prev_rdy = 1'b0;
  logic        prev_flush = 1'b0;
  logic [31:0] prev_res = '0;

  always @(negedge clk) begin
    exp_t e;
    int   a;
    if (!rst_n) begin
      prev_vld = 1'b0;
    end else begin
      if (out_valid && !prev_vld) begin
        if (lat_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_out_valid: got out_valid=1, expected no pending request");
        end else begin
          a = lat_q.pop_front();
          check32("latency", 32'(cyc - a), 32'd5);
        end
      end
      if (prev_vld && !prev_rdy && !prev_flush) begin
        check32("hold_valid", 32'(out_valid), 32'd1);
        check32("hold_result", result, prev_res);
      end
      if (out_valid) check32("done_in_ready", 32'(in_ready), 32'd0);
      if (out_valid && out_ready && !flush) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_handshake: got result %h, expected none", result);
        end else begin
          e = exp_q.pop_front();
          check32("result", result, e.word);
          check32("lead_run", 32'(lead_run(result, e.bv)), 32'(e.n));
          last_word = e.word;
        end
      end
      prev_vld   = out_valid;
      prev_rdy   = out_ready;
      prev_flush = flush;
      prev_res   = result;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] f;
    logic [31:0] w;
    int          seen;
    int          sel;
    logic [5:0]  c;

    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    bit_val   = 1'b0;
    count     = '0;
    fill      = '0;
    out_ready = 1'b1;
    last_word = '0;

    #3;
    check32("rst_out_valid", 32'(out_valid), 32'd0);
    check32("rst_result", result, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    tick();
    check32("post_rst_in_ready", 32'(in_ready), 32'd1);
    check32("post_rst_out_valid", 32'(out_valid), 32'd0);
    check32("post_rst_result", result, 32'h0);

    // Directed words, including clamp and full-run corners.
    send(1'b0, 6'd5,  32'hFFFF_FFFF);
    check32("dir_word_a", ref_word(1'b0, 5, 32'hFFFF_FFFF), 32'h07FF_FFFF);
    send(1'b1, 6'd12, 32'h0000_0000);
    send(1'b1, 6'd0,  32'hFFFF_FFFF);
    send(1'b0, 6'd40, 32'hDEAD_BEEF);
    send(1'b1, 6'd31, $urandom);
    send(1'b1, 6'd32, 32'h1234_5678);
    send(1'b0, 6'd63, 32'hFFFF_FFFF);
    send(1'b0, 6'd8,  32'h0000_0000);
    wait_drain();
    check32("dir_last_word", last_word, 32'h0080_0000);

    // Backpressure: hold the result ten cycles, then release.
    out_ready = 1'b0;
    send(1'b1, 6'd20, $urandom);
    wait_out_valid();
    repeat (10) tick();
    check32("bp_in_ready", 32'(in_ready), 32'd0);
    check32("bp_out_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    tick();
    check32("bp_release_valid", 32'(out_valid), 32'd0);
    check32("bp_release_ready", 32'(in_ready), 32'd1);

    // Flush in BUILD (idx=2) with a competing request: only byte 3 was written.
    f = $urandom;
    w = ref_word(1'b0, 7, f);
    send(1'b0, 6'd7, f);
    tick();
    flush    = 1'b1;
    in_valid = 1'b1;
    void'(exp_q.pop_back());
    void'(lat_q.pop_back());
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check32("flush_build_valid", 32'(out_valid), 32'd0);
    check32("flush_build_ready", 32'(in_ready), 32'd1);
    check32("flush_build_result", result, {w[31:24], last_word[23:0]});
    seen = 0;
    repeat (8) begin
      tick();
      if (out_valid) seen++;
    end
    check32("flush_build_no_out", 32'(seen), 32'd0);

    // Flush in IDLE together with in_valid: nothing accepted.
    flush    = 1'b1;
    in_valid = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check32("flush_idle_ready", 32'(in_ready), 32'd1);
    seen = 0;
    repeat (7) begin
      tick();
      if (out_valid) seen++;
    end
    check32("flush_idle_no_out", 32'(seen), 32'd0);

    // Flush in DONE together with out_ready: no handshake, result kept.
    out_ready = 1'b0;
    f = $urandom;
    w = ref_word(1'b1, 3, f);
    send(1'b1, 6'd3, f);
    wait_out_valid();
    out_ready = 1'b1;
    flush     = 1'b1;
    void'(exp_q.pop_back());
    tick();
    flush = 1'b0;
    check32("flush_done_valid", 32'(out_valid), 32'd0);
    check32("flush_done_result", result, w);

    // Reset pulse mid-BUILD: outputs drop at once, next request completes.
    send(1'b1, 6'd9, $urandom);
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    check32("arst_out_valid", 32'(out_valid), 32'd0);
    check32("arst_in_ready", 32'(in_ready), 32'd1);
    check32("arst_result", result, 32'h0);
    void'(exp_q.pop_back());
    void'(lat_q.pop_back());
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    send(1'b0, 6'd17, $urandom);
    wait_drain();

    // Random traffic with random consumer stalls.
    bp_rand = 1'b1;
    for (int t = 0; t < 40; t++) begin
      sel = int'($urandom_range(0, 3));
      case (sel)
        0:       c = 6'($urandom_range(0, 63));
        1:       c = 6'($urandom_range(30, 34));
        2:       c = ($urandom_range(0, 1) != 0) ? 6'd32 : 6'd0;
        default: c = 6'($urandom_range(0, 31));
      endcase
      send(1'($urandom), c, $urandom);
    end
    bp_rand   = 1'b0;
    out_ready = 1'b1;
    wait_drain();
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
